// File: rtl/sprite_attr_ram_ctl_if.sv
// Sprite attribute RAM port bundle: CPU-side byte-masked writes, renderer-side reads,
// clear request and busy status.
interface sprite_attr_ram_ctl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_BYTES = 4
) ();
    localparam int unsigned DW = 8 * DATA_BYTES;

    logic                  clear_i;
    logic                  busy_o;
    logic                  wr_en_i;
    logic [DATA_BYTES-1:0] wr_ben_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DW-1:0]         wr_data_i;
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [DW-1:0]         rd_data_o;

    modport master (
        output clear_i, wr_en_i, wr_ben_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
        input  busy_o, rd_data_o
    );

    modport slave (
        input  clear_i, wr_en_i, wr_ben_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
        output busy_o, rd_data_o
    );
endinterface

// File: rtl/sprite_attr_ram_ctl.sv
// Sprite attribute memory: byte-masked writes, registered reads with write-first
// forwarding, and a sweep engine that zeroes every entry after reset or on request.
module sprite_attr_ram_ctl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sprite_attr_ram_ctl_if.slave bus
);
    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  busy_q, busy_d;
    logic [DW-1:0]         rd_data_q, rd_data_d;

    logic [DW-1:0]         mem [DEPTH];
    logic [DATA_BYTES-1:0] mem_ben;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         rd_raw;
    logic                  collide;

    // Next state, single memory write port selection and read-data forwarding
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        rd_data_d = rd_data_q;
        mem_ben   = '0;
        mem_addr  = bus.wr_addr_i;
        mem_wdata = bus.wr_data_i;
        rd_raw    = mem[bus.rd_addr_i];
        collide   = bus.wr_en_i && (bus.wr_addr_i == bus.rd_addr_i);

        case (state_q)
            ST_CLEAR: begin
                mem_ben   = '1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
                if (bus.rd_en_i) begin
                    rd_data_d = '0;
                end
            end
            ST_READY: begin
                if (bus.wr_en_i) begin
                    mem_ben = bus.wr_ben_i;
                end
                if (bus.rd_en_i) begin
                    for (int unsigned n = 0; n < DATA_BYTES; n++) begin
                        rd_data_d[8*n +: 8] = (collide && bus.wr_ben_i[n])
                                            ? bus.wr_data_i[8*n +: 8]
                                            : rd_raw[8*n +: 8];
                    end
                end
                // The write above still lands this edge; the sweep then overwrites it
                if (bus.clear_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                busy_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array: no reset, byte-lane write enables only
    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < DATA_BYTES; n++) begin
            if (!rst && mem_ben[n]) begin
                mem[mem_addr][8*n +: 8] <= mem_wdata[8*n +: 8];
            end
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.rd_data_o = rd_data_q;

endmodule

// File: tb/tb_sprite_attr_ram_ctl.sv
// Self-checking bench for sprite_attr_ram_ctl: vector table, clear/reset sequences and
// randomized traffic against a behavioural memory model.
module tb_sprite_attr_ram_ctl;
    localparam int unsigned AW    = 8;
    localparam int unsigned NB    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk;
    logic rst;

    sprite_attr_ram_ctl_if #(.ADDR_WIDTH(AW), .DATA_BYTES(NB)) bus ();

    sprite_attr_ram_ctl #(.ADDR_WIDTH(AW), .DATA_BYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a sweep is modelled as a remaining-cycle count, memory as an array
    logic [31:0] m_mem [DEPTH];
    int          clr_left = 0;
    logic [31:0] m_rd     = 32'h0;

    typedef struct {
        logic        wr_en;
        logic [3:0]  ben;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        rd_en;
        logic [7:0]  raddr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] old;
        if (rst) begin
            clr_left = DEPTH;
            m_rd     = 32'h0;
            model_zero();
        end else if (clr_left > 0) begin
            if (bus.rd_en_i) m_rd = 32'h0;
            clr_left--;
        end else begin
            old = m_mem[bus.rd_addr_i];
            if (bus.rd_en_i) begin
                m_rd = old;
                if (bus.wr_en_i && bus.wr_addr_i == bus.rd_addr_i)
                    for (int b = 0; b < 4; b++)
                        if (bus.wr_ben_i[b]) m_rd[8*b +: 8] = bus.wr_data_i[8*b +: 8];
            end
            if (bus.wr_en_i)
                for (int b = 0; b < 4; b++)
                    if (bus.wr_ben_i[b]) m_mem[bus.wr_addr_i][8*b +: 8] = bus.wr_data_i[8*b +: 8];
            if (bus.clear_i) begin
                clr_left = DEPTH;
                model_zero();
            end
        end
    endtask

    // One clock: advance the model with the applied inputs, then check the outputs
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", 32'(bus.busy_o), 32'(clr_left > 0));
        chk("rd_data", bus.rd_data_o, m_rd);
    endtask

    task automatic idle();
        bus.clear_i   = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.wr_ben_i  = 4'h0;
        bus.wr_addr_i = 8'h00;
        bus.wr_data_i = 32'h0;
        bus.rd_en_i   = 1'b0;
        bus.rd_addr_i = 8'h00;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (bus.busy_o && n < 1000) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(DEPTH));
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < int'(DEPTH); a++) begin
            idle();
            bus.rd_en_i   = 1'b1;
            bus.rd_addr_i = 8'(a);
            tick();
            chk(name, bus.rd_data_o, 32'h0);
        end
        idle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 8'h02, 32'hDEADBEEF, 1'b0, 8'h00, 32'h00000000};
        vecs[1]  = '{1'b1, 4'h5, 8'h02, 32'h11223344, 1'b0, 8'h00, 32'h00000000};
        vecs[2]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h02, 32'hDE22BE44};
        vecs[3]  = '{1'b1, 4'hF, 8'h10, 32'hAABBCCDD, 1'b0, 8'h00, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 4'h8, 8'h10, 32'h01020304, 1'b1, 8'h10, 32'h01BBCCDD};
        vecs[5]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h10, 32'h01BBCCDD};
        vecs[6]  = '{1'b1, 4'hF, 8'h10, 32'h55555555, 1'b0, 8'h10, 32'h01BBCCDD};
        vecs[7]  = '{1'b1, 4'h1, 8'h10, 32'h000000AA, 1'b0, 8'h10, 32'h01BBCCDD};
        vecs[8]  = '{1'b1, 4'h0, 8'h10, 32'hFFFFFFFF, 1'b0, 8'h10, 32'h01BBCCDD};
        vecs[9]  = '{1'b1, 4'h2, 8'h10, 32'h0000BB00, 1'b0, 8'h10, 32'h01BBCCDD};
        vecs[10] = '{1'b0, 4'h0, 8'h10, 32'h00000000, 1'b0, 8'h10, 32'h01BBCCDD};
        vecs[11] = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h10, 32'h5555BBAA};
        vecs[12] = '{1'b1, 4'hF, 8'h20, 32'h12345678, 1'b1, 8'h02, 32'hDE22BE44};
        vecs[13] = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h20, 32'h12345678};
        vecs[14] = '{1'b1, 4'h0, 8'h20, 32'hCAFEF00D, 1'b1, 8'h20, 32'h12345678};

        idle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        count_busy("reset_sweep_len");
        read_all_zero("post_reset_zero");

        for (int i = 0; i < 15; i++) begin
            bus.wr_en_i   = vecs[i].wr_en;
            bus.wr_ben_i  = vecs[i].ben;
            bus.wr_addr_i = vecs[i].waddr;
            bus.wr_data_i = vecs[i].wdata;
            bus.rd_en_i   = vecs[i].rd_en;
            bus.rd_addr_i = vecs[i].raddr;
            tick();
            chk($sformatf("vec%0d", i), bus.rd_data_o, vecs[i].exp_rd);
        end
        idle();

        // Fill, then clear with a dropped write and an ignored second request
        for (int a = 0; a < int'(DEPTH); a++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_ben_i  = 4'hF;
            bus.wr_addr_i = 8'(a);
            bus.wr_data_i = 32'hFFFFFFFF;
            tick();
        end
        idle();
        bus.clear_i = 1'b1;
        tick();
        begin
            int n = 0;
            while (bus.busy_o && n < 1000) begin
                idle();
                if (n == 5) begin
                    bus.wr_en_i   = 1'b1;
                    bus.wr_ben_i  = 4'hF;
                    bus.wr_addr_i = 8'h05;
                    bus.wr_data_i = 32'h12345678;
                end
                if (n == 99) bus.clear_i = 1'b1;
                tick();
                n++;
            end
            chk("clear_sweep_len", 32'(n), 32'(DEPTH));
        end
        read_all_zero("post_clear_zero");

        // Reset in the middle of a sweep restarts it
        bus.clear_i = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 50; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy("rst_mid_clear_len");

        // Randomized traffic on a narrow address window to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 999) == 0);
            bus.clear_i   = ($urandom_range(0, 199) == 0);
            bus.wr_en_i   = 1'($urandom_range(0, 1));
            bus.wr_ben_i  = 4'($urandom_range(0, 15));
            bus.wr_addr_i = 8'($urandom_range(0, 7));
            bus.wr_data_i = $urandom;
            bus.rd_en_i   = 1'($urandom_range(0, 1));
            bus.rd_addr_i = 8'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
